// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants and types for the instruction fetch stage
package fetch_unit_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSN         = 32'h0000_0013;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // One queued instruction together with the address it was fetched from.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] word;
   } fetch_entry_t;

   // Instruction memory is word addressed; low address bits never reach it.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response channel
interface fetch_unit_if;
   import fetch_unit_pkg::*;

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rdata;

   modport master (
      output imem_req_valid,
      output imem_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req_valid,
      input  imem_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small synchronous FIFO with flush, used for instructions and PC tags
module fetch_queue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   input  logic                   flush,
   output logic [$clog2(DEPTH):0] count,
   output logic [WIDTH-1:0]       head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   // Popping an empty queue is ignored; a push into a full queue only lands if a pop frees a slot.
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != FULL_CNT) || do_pop);

   // Pointer and occupancy bookkeeping; flush discards every entry at once.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: count decides whether the head is meaningful.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, request issue, response queue and redirect flush for the fetch stage
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int              DEPTH    = 4
) (
   input  logic            clk,
   input  logic            rst,
   fetch_unit_if.master    imem,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            halt,
   output logic [XLEN-1:0] ir,
   output logic [XLEN-1:0] ir_pc,
   output logic            ir_valid,
   input  logic            ir_ready
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

   logic [XLEN-1:0] pc;
   logic [CW-1:0]   drop;
   logic [CW-1:0]   inflight;
   logic [CW-1:0]   q_count;
   logic [CW-1:0]   tag_count;
   logic [XLEN-1:0] tag_head;
   fetch_entry_t    q_head;
   fetch_entry_t    q_push_data;
   logic [CW:0]     budget;

   logic deq;
   logic accept;
   logic rsp;
   logic discard;
   logic enq;

   assign deq     = ir_valid && ir_ready;
   assign accept  = imem.imem_req_valid && imem.imem_req_ready;
   assign rsp     = imem.imem_rsp_valid;
   assign discard = rsp && (redirect_valid || (drop != '0));
   assign enq     = rsp && !discard;

   // Tags are flushed on redirect and stale responses are counted by drop instead,
   // so everything outstanding is exactly the live tags plus the pending discards.
   assign inflight = tag_count + drop;

   // A slot for a new request exists once in-flight words plus queued words, net of this
   // cycle's dequeue, leave room; this keeps every response guaranteed a queue entry.
   assign budget = {1'b0, inflight} + {1'b0, q_count} - {{CW{1'b0}}, deq};

   assign imem.imem_req_valid = !rst && !halt && !redirect_valid &&
                                (budget < {1'b0, DEPTH_CNT});
   assign imem.imem_addr      = pc;

   assign q_push_data = '{pc: tag_head, word: imem.imem_rdata};

   assign ir_valid = (q_count != '0);
   assign ir       = ir_valid ? q_head.word : NOP_INSN;
   assign ir_pc    = ir_valid ? q_head.pc   : '0;

   // Next fetch address: redirect wins over everything, otherwise advance on each accepted request.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (redirect_valid) begin
         pc <= word_align(redirect_pc);
      end else if (accept) begin
         pc <= pc + 32'd4;
      end
   end

   // Count of responses still owed by the memory for requests made before the last redirect.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop <= '0;
      end else if (redirect_valid) begin
         drop <= inflight - {{(CW-1){1'b0}}, rsp};
      end else if (rsp && (drop != '0)) begin
         drop <= drop - CW'(1);
      end
   end

   fetch_queue #(
      .WIDTH (XLEN),
      .DEPTH (DEPTH)
   ) u_tag_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (accept),
      .push_data (pc),
      .pop       (rsp && (drop == '0)),
      .flush     (redirect_valid),
      .count     (tag_count),
      .head      (tag_head)
   );

   fetch_queue #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_insn_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (enq),
      .push_data (q_push_data),
      .pop       (deq),
      .flush     (redirect_valid),
      .count     (q_count),
      .head      (q_head)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic [31:0] ir;
   logic [31:0] ir_pc;
   logic        ir_valid;
   logic        ir_ready;

   int checks = 0;
   int errors = 0;

   int          lat = 1;
   int          cyc = 0;
   logic [31:0] pend_addr[$];
   int          pend_due[$];
   logic [31:0] acc_log[$];
   logic [31:0] del_pc[$];
   logic [31:0] del_word[$];

   fetch_unit_if bus ();

   fetch_unit #(
      .RESET_PC (32'h0000_0100),
      .DEPTH    (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem           (bus),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .ir             (ir),
      .ir_pc          (ir_pc),
      .ir_valid       (ir_valid),
      .ir_ready       (ir_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: in-order responses lat cycles after acceptance, word = ~address, cleared by rst.
   always @(posedge clk) begin
      if (rst) begin
         pend_addr.delete();
         pend_due.delete();
         bus.imem_rsp_valid <= 1'b0;
         bus.imem_rdata     <= '0;
      end else begin
         if (bus.imem_req_valid && bus.imem_req_ready) begin
            acc_log.push_back(bus.imem_addr);
            pend_addr.push_back(bus.imem_addr);
            pend_due.push_back(cyc + lat - 1);
         end
         if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            bus.imem_rsp_valid <= 1'b1;
            bus.imem_rdata     <= ~pend_addr[0];
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
         end else begin
            bus.imem_rsp_valid <= 1'b0;
         end
      end
      cyc++;
   end

   // Record every instruction the consumer takes.
   always @(posedge clk) begin
      if (!rst && ir_valid && ir_ready) begin
         del_pc.push_back(ir_pc);
         del_word.push_back(ir);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Hold reset for a few cycles, then release; returns at the start of cycle 1.
   task automatic do_reset(input int l, input logic rdy);
      @(negedge clk);
      rst = 1'b1;
      halt = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      ir_ready = 1'b0;
      bus.imem_req_ready = 1'b1;
      lat = l;
      repeat (2) @(negedge clk);
      acc_log.delete();
      del_pc.delete();
      del_word.delete();
      @(negedge clk);
      rst = 1'b0;
      ir_ready = rdy;
   endtask

   initial begin
      rst = 1'b1;
      halt = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      ir_ready = 1'b0;
      bus.imem_req_ready = 1'b1;

      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ir_valid", ir_valid, 32'd0);
      chk("rst_ir", ir, 32'h0000_0013);
      chk("rst_ir_pc", ir_pc, 32'd0);
      chk("rst_req_valid", bus.imem_req_valid, 32'd0);

      // streaming at L=1 with the consumer always ready
      do_reset(1, 1'b1);
      #1;
      chk("t1_req_valid_c1", bus.imem_req_valid, 32'd1);
      chk("t1_addr_c1", bus.imem_addr, 32'h100);
      @(negedge clk); #1;
      chk("t1_ir_valid_c2", ir_valid, 32'd0);
      chk("t1_addr_c2", bus.imem_addr, 32'h104);
      @(negedge clk); #1;
      chk("t1_ir_valid_c3", ir_valid, 32'd1);
      chk("t1_ir_pc_c3", ir_pc, 32'h100);
      chk("t1_ir_c3", ir, 32'hFFFF_FEFF);
      for (int k = 4; k <= 8; k++) begin
         @(negedge clk); #1;
         chk("t1_stream_valid", ir_valid, 32'd1);
         chk("t1_stream_pc", ir_pc, 32'h100 + 32'(4 * (k - 3)));
      end

      // consumer stalled: queue fills, issue stops, then drains in order
      do_reset(1, 1'b0);
      repeat (9) @(negedge clk);
      #1;
      chk("t2_req_valid_full", bus.imem_req_valid, 32'd0);
      chk("t2_accept_count", 32'(acc_log.size()), 32'd4);
      chk("t2_ir_pc_head", ir_pc, 32'h100);
      @(negedge clk);
      ir_ready = 1'b1;
      #1;
      chk("t2_req_on_deq", bus.imem_req_valid, 32'd1);
      chk("t2_addr_resume", bus.imem_addr, 32'h110);
      repeat (6) @(negedge clk);
      #1;
      chk("t2_delivered_count", 32'(del_pc.size() >= 5), 32'd1);
      if (del_pc.size() >= 5) begin
         for (int i = 0; i < 5; i++) begin
            chk("t2_drain_pc", del_pc[i], 32'h100 + 32'(4 * i));
            chk("t2_drain_word", del_word[i], ~(32'h100 + 32'(4 * i)));
         end
      end

      // redirect with 2 in flight and 1 queued, response and ready in the same cycle
      do_reset(3, 1'b0);
      repeat (3) @(negedge clk);
      bus.imem_req_ready = 1'b0;
      #1;
      chk("t3_accepts_before", 32'(acc_log.size()), 32'd3);
      @(negedge clk);
      bus.imem_req_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_2003;
      #1;
      chk("t3_no_req_in_redirect", bus.imem_req_valid, 32'd0);
      chk("t3_head_before", ir_pc, 32'h100);
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      chk("t3_flushed", ir_valid, 32'd0);
      chk("t3_req_valid_after", bus.imem_req_valid, 32'd1);
      chk("t3_addr_target", bus.imem_addr, 32'h2000);
      for (int k = 7; k <= 9; k++) begin
         @(negedge clk); #1;
         chk("t3_no_stale_valid", ir_valid, 32'd0);
      end
      @(negedge clk); #1;
      chk("t3_target_valid", ir_valid, 32'd1);
      chk("t3_target_pc", ir_pc, 32'h2000);
      chk("t3_target_word", ir, 32'hFFFF_DFFF);
      chk("t3_fourth_accept", (acc_log.size() >= 4) ? acc_log[3] : 32'hDEAD_BEEF, 32'h2000);
      ir_ready = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      chk("t3_del_first", (del_pc.size() >= 2) ? del_pc[0] : 32'hDEAD_BEEF, 32'h2000);
      chk("t3_del_second", (del_pc.size() >= 2) ? del_pc[1] : 32'hDEAD_BEEF, 32'h2004);

      // halt with one request in flight, then resume
      do_reset(1, 1'b1);
      @(negedge clk);
      halt = 1'b1;
      #1;
      chk("t5_halt_no_req", bus.imem_req_valid, 32'd0);
      @(negedge clk); #1;
      chk("t5_word_delivered", ir_valid, 32'd1);
      chk("t5_word_pc", ir_pc, 32'h100);
      chk("t5_halt_no_req_c3", bus.imem_req_valid, 32'd0);
      for (int k = 4; k <= 6; k++) begin
         @(negedge clk); #1;
         chk("t5_halt_idle_req", bus.imem_req_valid, 32'd0);
         chk("t5_halt_idle_valid", ir_valid, 32'd0);
      end
      @(negedge clk);
      halt = 1'b0;
      #1;
      chk("t5_resume_valid", bus.imem_req_valid, 32'd1);
      chk("t5_resume_addr", bus.imem_addr, 32'h104);

      // PC wrap after redirect, then reset mid-burst
      repeat (3) @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      #1;
      chk("t6_no_req_in_redirect", bus.imem_req_valid, 32'd0);
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      chk("t6_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
      chk("t6_req_top", bus.imem_req_valid, 32'd1);
      chk("t6_empty_nop", ir, 32'h0000_0013);
      @(negedge clk); #1;
      chk("t6_addr_wrap", bus.imem_addr, 32'h0000_0000);
      chk("t6_req_wrap", bus.imem_req_valid, 32'd1);
      @(negedge clk); #1;
      chk("t6_ir_valid_top", ir_valid, 32'd1);
      chk("t6_ir_pc_top", ir_pc, 32'hFFFF_FFFC);
      chk("t6_ir_top", ir, 32'h0000_0003);
      @(negedge clk); #1;
      chk("t6_ir_pc_wrap", ir_pc, 32'h0000_0000);
      chk("t6_ir_wrap", ir, 32'hFFFF_FFFF);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t6_rst_req_valid", bus.imem_req_valid, 32'd0);
      @(negedge clk); #1;
      chk("t6_rst_ir_valid", ir_valid, 32'd0);
      chk("t6_rst_ir", ir, 32'h0000_0013);
      chk("t6_rst_ir_pc", ir_pc, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
